mem_align_unit: RTL
===================

# mem_align_unit

Load/store alignment and memory-handshake unit for the execute/memory stage of the RV32 core. It takes a byte address, store data and a load/store opcode, drives a word-aligned request with byte enables to data memory, waits for the acknowledge, then returns sign- or zero-extended load data. It performs the memory-side byte-lane shift that complements the core's ALU shift path: left into lanes for stores, right with extension for loads.

## Interface
- WAIT_MAX, 15: REQ cycles without mem_ack before bus-error completion; legal range 1..255.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operation valid; sampled only in IDLE.
- i  in  instruction_type  LB/LBU/LH/LHU/LW/SB/SH/SW.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- result_out  out  32  load result; held between load completions.
- misaligned  out  1  pulses with done on a trapped misaligned access.
- bus_err  out  1  pulses with done on timeout.
- mem_req  out  1  request; held high until mem_ack or timeout.
- mem_we  out  1  1 = store.
- mem_be  out  4  byte enables.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-shifted store data.
- mem_ack  in  1  memory acknowledge; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE with start=1: latch i, addr, wdata; go to REQ. With a trapped misalignment, go directly to DONE.
  - REQ: mem_req=1. mem_ack=1 captures data and moves to DONE. Otherwise the wait counter increments; when it reaches WAIT_MAX, move to DONE with an error.
  - DONE: done=1 for one cycle, then IDLE.
- Byte enables by offset o=addr[1:0]:
  - Byte: 4'b0001<<o.
  - Half: 4'b0011<<{o[1],1'b0}.
  - Word: 4'b1111.
- Store data: mem_wdata = wdata<<(8*o). Bytes outside the enabled lanes are don't-care; drive the shifted value.
- Load data:
  - Extraction: x = mem_rdata>>(8*o).
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes x unchanged.
- Stores never change result_out. Error and misaligned completions never change result_out.
- Misaligned means:
  - Half access with o[0]=1.
  - Word access with o!=0.
- start while busy is ignored. mem_ack in IDLE or DONE is ignored.
- If mem_ack arrives in the same cycle the counter hits WAIT_MAX, the ack wins.

## Timing
- All outputs are registered.
- Reset values:
  - busy=0, done=0, misaligned=0, bus_err=0.
  - mem_req=0, mem_we=0, mem_be=0.
  - mem_addr=0, mem_wdata=0, result_out=0.
  - FSM in IDLE, counter=0.
- start sampled at edge 0: mem_req is high from cycle 1. An ack sampled at edge k gives done (and a valid result_out) in cycle k+1. A zero-wait access completes with done in cycle 2.
- A trapped misaligned access has done in cycle 1, with no mem_req.
- Timeout: done and bus_err in cycle WAIT_MAX+1. mem_req is low in the done cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The in-flight access is abandoned and produces no done. A late mem_ack is ignored.

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned access issues no memory request and completes with done=1, misaligned=1.
- MISALIGN_TRAP_EN undefined: misaligned never asserts (tied 0). The offending low address bits are masked (half: o[0]=0; word: o=0) and the access proceeds normally.

## Structure
- my_pkg additions:
  - Enumerators LB, LBU, LH, LHU, LW, SB, SH, SW in instruction_type.
  - FSM state typedef.
  - Constant MEM_WAIT_MAX_DEF=15.
- One combinational sub-module, mem_lane_align, computes mem_be, mem_wdata and the extended load value from op, offset, wdata and rdata. The top level holds the FSM, counter and registers.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ack in cycle 1 -> mem_addr=0x100, mem_be=4'b1111, mem_we=1, mem_wdata=0xDEADBEEF, done in cycle 2, result_out unchanged.
- SB addr 0x103, wdata 0x000000A5 -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xA5000000.
- Loads with mem_rdata=0x12F48001:
  - LB addr 0x102 -> result_out=0xFFFFFFF4.
  - LBU addr 0x102 -> 0x000000F4.
  - LH addr 0x100 -> 0xFFFF8001.
  - LHU addr 0x100 -> 0x00008001.
- LW addr 0x202:
  - With MISALIGN_TRAP_EN -> done and misaligned in cycle 1, mem_req never high.
  - Without -> mem_addr=0x200, mem_be=4'b1111, normal completion.
- LW with no ack, WAIT_MAX=15 -> done and bus_err in cycle 16, mem_req low from cycle 16, result_out unchanged.
- reset asserted in cycle 3 of REQ, ack in cycle 4 -> mem_req and busy drop immediately, no done pulse, FSM in IDLE.

Source files
------------

// File: rtl/mem_align_unit_pkg.sv
// mem_align_unit_pkg
// Shared types and constants for the load/store alignment unit.
//   instruction_type : load/store opcodes handled by the unit
//   state_t          : handshake FSM states
//   MEM_WAIT_MAX_DEF : default number of REQ cycles before a bus-error completion
// Helper functions classify an opcode by direction and access width.
package mem_align_unit_pkg;

    typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, SB, SH, SW} instruction_type;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int MEM_WAIT_MAX_DEF = 15;

    function automatic logic is_store(input instruction_type op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_half(input instruction_type op);
        return (op == LH) || (op == LHU) || (op == SH);
    endfunction

    function automatic logic is_word(input instruction_type op);
        return (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/mem_align_unit_lane.sv
// mem_lane_align
// Combinational byte-lane steering between the core and a 32-bit data memory.
//   i_op    : load/store opcode
//   i_off   : byte offset within the word (already masked when misalignment is not trapped)
//   i_wdata : store data from the core (rs2)
//   i_rdata : word read from memory
//   o_be    : byte enables for the access
//   o_wdata : store data shifted into its byte lanes
//   o_ldata : load data shifted down and sign/zero extended
module mem_lane_align
    import mem_align_unit_pkg::*;
(
    input  instruction_type i_op,
    input  logic [1:0]      i_off,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_rdata,
    output logic [3:0]      o_be,
    output logic [31:0]     o_wdata,
    output logic [31:0]     o_ldata
);

    logic [4:0]  w_shift;
    logic [31:0] w_x;

    assign w_shift = {i_off, 3'b000};
    assign o_wdata = i_wdata << w_shift;
    assign w_x     = i_rdata >> w_shift;

    always_comb begin
        o_be    = 4'b1111;
        o_ldata = w_x;
        case (i_op)
            LB: begin
                o_be    = 4'b0001 << i_off;
                o_ldata = {{24{w_x[7]}}, w_x[7:0]};
            end
            LBU: begin
                o_be    = 4'b0001 << i_off;
                o_ldata = {24'h0, w_x[7:0]};
            end
            SB: o_be = 4'b0001 << i_off;
            LH: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_ldata = {{16{w_x[15]}}, w_x[15:0]};
            end
            LHU: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_ldata = {16'h0, w_x[15:0]};
            end
            SH: o_be = 4'b0011 << {i_off[1], 1'b0};
            default: begin
                o_be    = 4'b1111;
                o_ldata = w_x;
            end
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit
// Load/store alignment and memory handshake for the execute/memory stage.
// Latches one load/store, issues a word-aligned request with byte enables,
// waits for mem_ack (or times out after WAIT_MAX cycles) and returns the
// extended load value.
// Optional feature: MISALIGN_TRAP_EN. When defined, misaligned accesses are
// completed at once with misaligned=1 and no memory request; when undefined
// the offending low address bits are masked and the access proceeds.
// Ports:
//   clk, reset (async, active-high)
//   start, i, addr, wdata          : operation request from the core
//   busy, done, result_out         : status and load result
//   misaligned, bus_err            : completion flags, pulse with done
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata            : request to data memory
//   mem_ack, mem_rdata             : response from data memory
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter int WAIT_MAX = MEM_WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  instruction_type i,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            busy,
    output logic            done,
    output logic [31:0]     result_out,
    output logic            misaligned,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata
);

    // Timeout fires on the REQ cycle whose count would reach WAIT_MAX.
    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t          r_state;
    logic [7:0]      r_cnt;
    instruction_type r_op;
    logic [1:0]      r_off;
    logic            r_busy, r_done, r_mis, r_err, r_req, r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_addr, r_wdata, r_result;

    logic            w_trap;
    logic [1:0]      w_off_in;
    instruction_type w_op_sel;
    logic [1:0]      w_off_sel;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata, w_ldata;

`ifdef MISALIGN_TRAP_EN
    assign w_trap   = (is_half(i) && addr[0]) || (is_word(i) && (addr[1:0] != 2'b00));
    assign w_off_in = addr[1:0];
`else
    assign w_trap   = 1'b0;
    assign w_off_in = is_word(i) ? 2'b00 :
                      is_half(i) ? {addr[1], 1'b0} : addr[1:0];
`endif

    // In IDLE the lane logic sees the incoming request so the bus fields can
    // be registered on the start edge; afterwards it sees the latched access
    // so the load extension uses the captured opcode and offset.
    assign w_op_sel  = (r_state == IDLE) ? i : r_op;
    assign w_off_sel = (r_state == IDLE) ? w_off_in : r_off;

    mem_lane_align u_lane (
        .i_op    (w_op_sel),
        .i_off   (w_off_sel),
        .i_wdata (wdata),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_op     <= LB;
            r_off    <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= 4'b0000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_result <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_mis  <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= i;
                        r_off  <= w_off_in;
                        r_busy <= 1'b1;
                        r_cnt  <= 8'd0;
                        if (w_trap) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_we    <= is_store(i);
                            r_be    <= w_be;
                            r_addr  <= {addr[31:2], 2'b00};
                            r_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (mem_ack) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!is_store(r_op)) begin
                            r_result <= w_ldata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign misaligned = r_mis;
    assign bus_err    = r_err;
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_be     = r_be;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign result_out = r_result;

endmodule
